// File: rtl/dmem_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_controller
// Purpose  : MEM-stage data-memory sequencer. Stalls the pipeline while a load
//            or store is outstanding, builds byte-lane strobes for stores,
//            extracts and extends load data, flags misaligned accesses and
//            memory timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_controller #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        StallM,
  output logic [31:0] ReadDataM,
  output logic        MisalignM,
  output logic        AccessFaultM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Last counter value before giving up on dmem_ready; the request is held
  // for exactly TIMEOUT cycles (counter values 0..TIMEOUT-1).
  localparam logic [7:0] C_TMO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_next;
  logic [7:0]  r_cnt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_rdata;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lo;
  logic        r_fault;

  logic        w_access;
  logic        w_is_byte;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_start;
  logic        w_timeout;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Size decode; reserved encodings fall into the word case.
  assign w_access  = MemReadM | MemWriteM;
  assign w_is_byte = (funct3M[1:0] == 2'b00);
  assign w_is_half = (funct3M[1:0] == 2'b01);
  assign w_is_word = ~w_is_byte & ~w_is_half;

  assign MisalignM = w_access & ((w_is_half & ALUResultM[0]) |
                                 (w_is_word & (ALUResultM[1:0] != 2'b00)));

  assign w_start   = (r_state == S_IDLE) & w_access & ~MisalignM;
  assign w_timeout = (r_state == S_REQ) & ~dmem_ready & (r_cnt == C_TMO_LAST);

  // State register: reset drops any in-flight access immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: IDLE -> REQ on a valid access, REQ -> RESP on ready or
  // timeout, RESP always returns to IDLE without accepting a new access.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_REQ;
      S_REQ:   if (dmem_ready || w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs: stall from the accepting IDLE cycle through the ready cycle.
  always_comb begin
    StallM = 1'b0;
    case (r_state)
      S_IDLE:  StallM = w_start;
      S_REQ:   StallM = 1'b1;
      default: StallM = 1'b0;
    endcase
  end

  // Store lane steering: replicate the right-justified data across lanes.
  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = WriteDataM;
    if (w_is_byte) begin
      w_wstrb = 4'b0001 << ALUResultM[1:0];
      w_wdata = {4{WriteDataM[7:0]}};
    end else if (w_is_half) begin
      w_wstrb = 4'b0011 << {ALUResultM[1], 1'b0};
      w_wdata = {2{WriteDataM[15:0]}};
    end
  end

  // Request registers, timeout counter, read latch and fault pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_wstrb  <= 4'h0;
      r_rdata  <= 32'h0;
      r_funct3 <= 3'h0;
      r_lo     <= 2'h0;
      r_cnt    <= 8'h0;
      r_fault  <= 1'b0;
    end else begin
      r_fault <= 1'b0;
      if (w_start) begin
        r_req    <= 1'b1;
        r_we     <= MemWriteM;
        r_addr   <= {ALUResultM[31:2], 2'b00};
        r_wdata  <= w_wdata;
        r_wstrb  <= MemWriteM ? w_wstrb : 4'b0000;
        r_funct3 <= funct3M;
        r_lo     <= ALUResultM[1:0];
        r_cnt    <= 8'h0;
      end else if (r_state == S_REQ) begin
        if (dmem_ready) begin
          r_req   <= 1'b0;
          r_rdata <= dmem_rdata;
        end else if (w_timeout) begin
          r_req   <= 1'b0;
          r_rdata <= 32'h0;
          r_fault <= 1'b1;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  // Load extraction and extension from the latched word.
  always_comb begin
    w_byte = r_rdata[{r_lo, 3'b000} +: 8];
    w_half = r_rdata[{r_lo[1], 4'b0000} +: 16];
    case (r_funct3[1:0])
      2'b00:   ReadDataM = {{24{w_byte[7] & ~r_funct3[2]}}, w_byte};
      2'b01:   ReadDataM = {{16{w_half[15] & ~r_funct3[2]}}, w_half};
      default: ReadDataM = r_rdata;
    endcase
  end

  assign AccessFaultM = r_fault;
  assign dmem_req     = r_req;
  assign dmem_we      = r_we;
  assign dmem_addr    = r_addr;
  assign dmem_wdata   = r_wdata;
  assign dmem_wstrb   = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_controller
// Purpose  : Directed self-checking bench for dmem_access_controller
//            (TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_access_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallM, MisalignM, AccessFaultM;
  logic [31:0] ReadDataM;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;

  int checks   = 0;
  int failures = 0;

  dmem_access_controller #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .StallM(StallM), .ReadDataM(ReadDataM), .MisalignM(MisalignM),
    .AccessFaultM(AccessFaultM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'b000;
    ALUResultM = 32'h0; WriteDataM = 32'h0;
    dmem_ready = 1'b0; dmem_rdata = 32'h0;
  endtask

  // One aligned access: presented in cycle 0, dmem_ready in cycle k, RESP in k+1.
  task automatic access(input string name, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int k, input logic [31:0] exp_rd,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
    MemReadM = rd; MemWriteM = wr; funct3M = f3;
    ALUResultM = addr; WriteDataM = wdata;
    #1;
    chk({name, "_c0_stall"}, 32'(StallM), 32'd1);
    chk({name, "_c0_req"}, 32'(dmem_req), 32'd0);
    for (int c = 1; c <= k; c++) begin
      cyc();
      dmem_ready = (c == k);
      dmem_rdata = (c == k) ? rdata : 32'h5A5A5A5A;
      #1;
      chk({name, "_req"}, 32'(dmem_req), 32'd1);
      chk({name, "_stall"}, 32'(StallM), 32'd1);
      if (c == k) begin
        chk({name, "_addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
        chk({name, "_we"}, 32'(dmem_we), 32'(wr));
        chk({name, "_wstrb"}, 32'(dmem_wstrb), 32'(exp_strb));
        if (wr) chk({name, "_wdata"}, dmem_wdata, exp_wdata);
      end
    end
    cyc();
    dmem_ready = 1'b0;
    dmem_rdata = 32'h5A5A5A5A;
    #1;
    chk({name, "_resp_stall"}, 32'(StallM), 32'd0);
    chk({name, "_resp_req"}, 32'(dmem_req), 32'd0);
    chk({name, "_resp_fault"}, 32'(AccessFaultM), 32'd0);
    if (rd && !wr) chk({name, "_rdata"}, ReadDataM, exp_rd);
    cyc();
    clear_inputs();
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_wstrb", 32'(dmem_wstrb), 32'd0);
    chk("rst_fault", 32'(AccessFaultM), 32'd0);
    chk("rst_rdata", ReadDataM, 32'h0);
    chk("rst_stall", 32'(StallM), 32'd0);
    rst = 1'b0;
    cyc();

    // Loads
    access("lw",  1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 4'b0000, 32'h0);
    access("lb",  1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 4, 32'hFFFF_FF80, 4'b0000, 32'h0);
    access("lbu", 1, 0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_0000, 2, 32'h0000_0080, 4'b0000, 32'h0);
    access("lh",  1, 0, 3'b001, 32'h0000_0102, 32'h0, 32'h80FF_0000, 1, 32'hFFFF_80FF, 4'b0000, 32'h0);
    access("lhu", 1, 0, 3'b101, 32'h0000_0100, 32'h0, 32'h1234_8001, 3, 32'h0000_8001, 4'b0000, 32'h0);
    access("lb0", 1, 0, 3'b000, 32'h0000_0100, 32'h0, 32'h1234_5678, 1, 32'h0000_0078, 4'b0000, 32'h0);

    // Stores
    access("sb",  0, 1, 3'b000, 32'h0000_0202, 32'h1234_56AB, 32'h0, 1, 32'h0, 4'b0100, 32'hABAB_ABAB);
    access("sh",  0, 1, 3'b001, 32'h0000_0202, 32'hFFFF_1234, 32'h0, 2, 32'h0, 4'b1100, 32'h1234_1234);
    access("sw",  0, 1, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'h0, 1, 32'h0, 4'b1111, 32'hCAFE_F00D);
    access("rw",  1, 1, 3'b010, 32'h0000_0208, 32'h0BAD_CAFE, 32'h0, 1, 32'h0, 4'b1111, 32'h0BAD_CAFE);

    // Misaligned: no request, no stall
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h0000_0101;
    #1;
    chk("mis_lw_flag", 32'(MisalignM), 32'd1);
    chk("mis_lw_stall", 32'(StallM), 32'd0);
    cyc();
    chk("mis_lw_req", 32'(dmem_req), 32'd0);
    funct3M = 3'b001; ALUResultM = 32'h0000_0103;
    #1;
    chk("mis_lh_flag", 32'(MisalignM), 32'd1);
    chk("mis_lh_stall", 32'(StallM), 32'd0);
    cyc();
    chk("mis_lh_req", 32'(dmem_req), 32'd0);
    clear_inputs();
    #1;

    // Warm the read latch with a non-zero word so the timeout zeroing shows.
    access("lw2", 1, 0, 3'b010, 32'h0000_0110, 32'h0, 32'h7777_1111, 1, 32'h7777_1111, 4'b0000, 32'h0);

    // Timeout: request held for cycles 1..4, fault in cycle 5
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h0000_0300;
    #1;
    chk("tmo_c0_stall", 32'(StallM), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      chk("tmo_req", 32'(dmem_req), 32'd1);
      chk("tmo_stall", 32'(StallM), 32'd1);
      chk("tmo_nofault", 32'(AccessFaultM), 32'd0);
    end
    cyc();
    chk("tmo_fault", 32'(AccessFaultM), 32'd1);
    chk("tmo_rdata", ReadDataM, 32'h0);
    chk("tmo_resp_req", 32'(dmem_req), 32'd0);
    chk("tmo_resp_stall", 32'(StallM), 32'd0);
    cyc();
    clear_inputs();
    #1;
    chk("tmo_idle_fault", 32'(AccessFaultM), 32'd0);
    chk("tmo_idle_stall", 32'(StallM), 32'd0);

    // Reset in the middle of REQ
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h0000_0400;
    cyc();
    chk("rmid_c1_req", 32'(dmem_req), 32'd1);
    cyc();
    chk("rmid_c2_req", 32'(dmem_req), 32'd1);
    rst = 1'b1;
    MemReadM = 1'b0;
    #1;
    chk("rmid_async_req", 32'(dmem_req), 32'd0);
    chk("rmid_async_stall", 32'(StallM), 32'd0);
    cyc();
    rst = 1'b0;
    dmem_ready = 1'b1; dmem_rdata = 32'h1111_1111;
    #1;
    chk("rmid_c3_req", 32'(dmem_req), 32'd0);
    chk("rmid_c3_stall", 32'(StallM), 32'd0);
    cyc();
    dmem_ready = 1'b0;
    #1;
    chk("rmid_ignored_rdata", ReadDataM, 32'h0);
    chk("rmid_ignored_fault", 32'(AccessFaultM), 32'd0);
    clear_inputs();
    access("lw_post", 1, 0, 3'b010, 32'h0000_0500, 32'h0, 32'h0BAD_F00D, 1, 32'h0BAD_F00D, 4'b0000, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
